// File: rtl/and_rr_scheduler.sv
// Round-robin scheduler sharing one N-bit AND datapath between R requesters.
// Flow per operation: IDLE (arbitrate and capture operands), COMPUTE (run the
// AND), RESULT (hold the result until the consumer takes it).

// N-bit bitwise AND datapath shared by all requesters.
module and_n #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  assign y = a & b;

endmodule

module and_rr_scheduler #(
  parameter int unsigned N     = 4,
  parameter int unsigned R     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [R-1:0]            req,
  input  logic [R*N-1:0]          a_in,
  input  logic [R*N-1:0]          b_in,
  output logic [R-1:0]            gnt,
  output logic [N-1:0]            s_out,
  output logic [$clog2(R)-1:0]    s_id,
  output logic                    s_valid,
  input  logic                    s_ready,
  output logic                    busy,
  output logic [CNT_W-1:0]        op_count
);

  localparam int unsigned IW = $clog2(R);
  // One extra bit so ptr + offset never overflows before the modulo-R fold.
  localparam int unsigned CW = IW + 1;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCompute = 2'd1;
  localparam logic [1:0] StResult  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [IW-1:0]    win_id_q, win_id_d;
  logic [N-1:0]     s_out_q, s_out_d;
  logic [IW-1:0]    s_id_q, s_id_d;
  logic             s_valid_q, s_valid_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             found;
  logic [IW-1:0]    win_idx;
  logic [CW-1:0]    cand;
  logic [N-1:0]     a_sel, b_sel;
  logic [N-1:0]     and_y;

  // Rotating-priority search: first set req bit from ptr upward, wrapping at R-1.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < R; i++) begin
      cand = {1'b0, ptr_q} + CW'(i);
      if (cand >= CW'(R)) begin
        cand = cand - CW'(R);
      end
      if (!found && req[cand[IW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
  end

  // Select the winning requester's operand slices.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < R; i++) begin
      if (win_idx == IW'(i)) begin
        a_sel = a_in[i*N +: N];
        b_sel = b_in[i*N +: N];
      end
    end
  end

  // Grant is only offered while idle; reset masks it immediately.
  always_comb begin
    gnt = '0;
    if (rst_n && (state_q == StIdle) && found) begin
      gnt[win_idx] = 1'b1;
    end
  end

  and_n #(
    .N (N)
  ) u_and (
    .a (a_q),
    .b (b_q),
    .y (and_y)
  );

  // Next-state logic for the IDLE -> COMPUTE -> RESULT cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    a_d        = a_q;
    b_d        = b_q;
    win_id_d   = win_id_q;
    s_out_d    = s_out_q;
    s_id_d     = s_id_q;
    s_valid_d  = s_valid_q;
    op_count_d = op_count_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          a_d      = a_sel;
          b_d      = b_sel;
          win_id_d = win_idx;
          state_d  = StCompute;
        end
      end
      StCompute: begin
        s_out_d   = and_y;
        s_id_d    = win_id_q;
        s_valid_d = 1'b1;
        state_d   = StResult;
      end
      StResult: begin
        // Priority rotates only on acceptance, so a stall never moves ptr.
        if (s_ready) begin
          s_valid_d  = 1'b0;
          op_count_d = op_count_q + CNT_W'(1);
          ptr_d      = (win_id_q == IW'(R - 1)) ? '0 : win_id_q + IW'(1);
          state_d    = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      win_id_q   <= '0;
      s_out_q    <= '0;
      s_id_q     <= '0;
      s_valid_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      win_id_q   <= win_id_d;
      s_out_q    <= s_out_d;
      s_id_q     <= s_id_d;
      s_valid_q  <= s_valid_d;
      op_count_q <= op_count_d;
    end
  end

  assign s_out    = s_out_q;
  assign s_id     = s_id_q;
  assign s_valid  = s_valid_q;
  assign busy     = (state_q != StIdle);
  assign op_count = op_count_q;

endmodule

// File: tb/tb_and_rr_scheduler.sv
// Self-checking bench for and_rr_scheduler: directed vector table, hand-written
// corner sequences and randomized traffic against a transaction-level model.
module tb_and_rr_scheduler;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int CNT_W = 8;
  localparam int IW    = 2;

  logic             clk;
  logic             rst_n;
  logic [R-1:0]     req;
  logic [R*N-1:0]   a_in;
  logic [R*N-1:0]   b_in;
  logic [R-1:0]     gnt;
  logic [N-1:0]     s_out;
  logic [IW-1:0]    s_id;
  logic             s_valid;
  logic             s_ready;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  and_rr_scheduler #(
    .N     (N),
    .R     (R),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .a_in     (a_in),
    .b_in     (b_in),
    .gnt      (gnt),
    .s_out    (s_out),
    .s_id     (s_id),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .busy     (busy),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Directed vector table: inputs for one cycle and outputs expected in that cycle.
  typedef struct {
    logic             rst;
    logic [R-1:0]     req;
    logic [R*N-1:0]   a;
    logic [R*N-1:0]   b;
    logic             rdy;
    logic [R-1:0]     gnt;
    logic             vld;
    logic [N-1:0]     out;
    logic [IW-1:0]    id;
    logic             busy;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t vecs[21];

  task automatic apply_vec(input int k, input vec_t v);
    @(negedge clk);
    rst_n   = !v.rst;
    req     = v.req;
    a_in    = v.a;
    b_in    = v.b;
    s_ready = v.rdy;
    #1;
    check($sformatf("vec%0d.gnt", k), 32'(gnt), 32'(v.gnt));
    check($sformatf("vec%0d.valid", k), 32'(s_valid), 32'(v.vld));
    check($sformatf("vec%0d.out", k), 32'(s_out), 32'(v.out));
    check($sformatf("vec%0d.id", k), 32'(s_id), 32'(v.id));
    check($sformatf("vec%0d.busy", k), 32'(busy), 32'(v.busy));
    check($sformatf("vec%0d.count", k), 32'(op_count), 32'(v.cnt));
  endtask

  // Transaction-level reference: an operation is absent, being computed, or
  // waiting for the consumer; priority pointer moves past the accepted id.
  int           m_ptr, m_phase, m_id, m_cnt;
  logic [N-1:0] m_data, m_out;
  int           m_sid;

  logic [R-1:0]  last_gnt;
  logic          last_vld, last_busy;
  logic [N-1:0]  last_out;
  logic [IW-1:0] last_id;
  logic [CNT_W-1:0] last_cnt;

  task automatic model_reset();
    m_ptr = 0; m_phase = 0; m_id = 0; m_cnt = 0; m_data = '0; m_out = '0; m_sid = 0;
  endtask

  function automatic int winner(input logic [R-1:0] r);
    for (int k = 0; k < R; k++) begin
      int idx;
      idx = (m_ptr + k) % R;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic cycle(input logic [R-1:0] r, input logic [R*N-1:0] a, input logic [R*N-1:0] b,
                       input logic rdy);
    int w;
    logic [R-1:0] eg;
    @(negedge clk);
    req = r; a_in = a; b_in = b; s_ready = rdy;
    #1;
    w  = winner(r);
    eg = '0;
    if (m_phase == 0 && w >= 0) eg[w] = 1'b1;
    last_gnt = gnt; last_vld = s_valid; last_busy = busy;
    last_out = s_out; last_id = s_id; last_cnt = op_count;
    check("model.gnt", 32'(gnt), 32'(eg));
    check("model.valid", 32'(s_valid), 32'(m_phase == 2));
    check("model.busy", 32'(busy), 32'(m_phase != 0));
    check("model.out", 32'(s_out), 32'(m_out));
    check("model.id", 32'(s_id), 32'(m_sid));
    check("model.count", 32'(op_count), 32'(m_cnt));
    @(posedge clk);
    if (m_phase == 0) begin
      if (w >= 0) begin
        m_phase = 1;
        m_id    = w;
        m_data  = a[w*N +: N] & b[w*N +: N];
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
      m_out   = m_data;
      m_sid   = m_id;
    end else if (rdy) begin
      m_phase = 0;
      m_cnt   = (m_cnt + 1) % (1 << CNT_W);
      m_ptr   = (m_id + 1) % R;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; s_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Pull reset mid-cycle with all requests high; everything must clear at once.
  task automatic async_reset(input string tag);
    @(negedge clk);
    req = '1;
    #2 rst_n = 1'b0;
    #1;
    check({tag, ".valid"}, 32'(s_valid), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".gnt"}, 32'(gnt), 32'd0);
    check({tag, ".count"}, 32'(op_count), 32'd0);
    check({tag, ".out"}, 32'(s_out), 32'd0);
    check({tag, ".id"}, 32'(s_id), 32'd0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  localparam logic [15:0] A1 = 16'h000C;
  localparam logic [15:0] B1 = 16'h000A;
  localparam logic [15:0] AF = 16'hFFFF;
  localparam logic [15:0] BI = 16'h3210;

  initial begin
    //            rst req  a   b   rdy  gnt  vld out  id busy cnt
    vecs[0]  = '{1'b0, 4'h1, A1, B1, 1'b1, 4'h1, 1'b0, 4'h0, 2'd0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 4'h0, A1, B1, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 1'b1, 8'd0};
    vecs[2]  = '{1'b0, 4'h0, A1, B1, 1'b1, 4'h0, 1'b1, 4'h8, 2'd0, 1'b1, 8'd0};
    vecs[3]  = '{1'b0, 4'h0, A1, B1, 1'b1, 4'h0, 1'b0, 4'h8, 2'd0, 1'b0, 8'd1};
    vecs[4]  = '{1'b1, 4'h0, A1, B1, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 4'hF, AF, BI, 1'b1, 4'h1, 1'b0, 4'h0, 2'd0, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 4'hF, AF, BI, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 1'b1, 8'd0};
    vecs[7]  = '{1'b0, 4'hF, AF, BI, 1'b1, 4'h0, 1'b1, 4'h0, 2'd0, 1'b1, 8'd0};
    vecs[8]  = '{1'b0, 4'hF, AF, BI, 1'b1, 4'h2, 1'b0, 4'h0, 2'd0, 1'b0, 8'd1};
    vecs[9]  = '{1'b0, 4'hF, AF, BI, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 1'b1, 8'd1};
    vecs[10] = '{1'b0, 4'hF, AF, BI, 1'b1, 4'h0, 1'b1, 4'h1, 2'd1, 1'b1, 8'd1};
    vecs[11] = '{1'b0, 4'hF, AF, BI, 1'b1, 4'h4, 1'b0, 4'h1, 2'd1, 1'b0, 8'd2};
    vecs[12] = '{1'b0, 4'hF, AF, BI, 1'b1, 4'h0, 1'b0, 4'h1, 2'd1, 1'b1, 8'd2};
    vecs[13] = '{1'b0, 4'hF, AF, BI, 1'b1, 4'h0, 1'b1, 4'h2, 2'd2, 1'b1, 8'd2};
    vecs[14] = '{1'b0, 4'hF, AF, BI, 1'b1, 4'h8, 1'b0, 4'h2, 2'd2, 1'b0, 8'd3};
    vecs[15] = '{1'b0, 4'hF, AF, BI, 1'b1, 4'h0, 1'b0, 4'h2, 2'd2, 1'b1, 8'd3};
    vecs[16] = '{1'b0, 4'hF, AF, BI, 1'b1, 4'h0, 1'b1, 4'h3, 2'd3, 1'b1, 8'd3};
    vecs[17] = '{1'b0, 4'hF, AF, BI, 1'b1, 4'h1, 1'b0, 4'h3, 2'd3, 1'b0, 8'd4};
    vecs[18] = '{1'b0, 4'hF, AF, BI, 1'b1, 4'h0, 1'b0, 4'h3, 2'd3, 1'b1, 8'd4};
    vecs[19] = '{1'b0, 4'hF, AF, BI, 1'b1, 4'h0, 1'b1, 4'h0, 2'd0, 1'b1, 8'd4};
    vecs[20] = '{1'b0, 4'h0, AF, BI, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0, 8'd5};

    rst_n = 1'b0; req = '0; a_in = '0; b_in = '0; s_ready = 1'b0;
    model_reset();
    #1;
    check("reset.gnt", 32'(gnt), 32'd0);
    check("reset.valid", 32'(s_valid), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.count", 32'(op_count), 32'd0);
    repeat (2) @(negedge clk);

    for (int k = 0; k < 21; k++) apply_vec(k, vecs[k]);

    // Wrap priority: serve requester 2 so ptr = 3, then 0011 must go to 0.
    do_reset();
    cycle(4'b0100, AF, BI, 1'b1);
    cycle(4'b0000, AF, BI, 1'b1);
    cycle(4'b0000, AF, BI, 1'b1);
    cycle(4'b0011, AF, BI, 1'b1);
    check("wrap_gnt", 32'(last_gnt), 32'b0001);
    cycle(4'b0000, AF, BI, 1'b1);
    cycle(4'b0000, AF, BI, 1'b1);
    cycle(4'b0011, AF, BI, 1'b1);
    check("ptr_after_wrap_gnt", 32'(last_gnt), 32'b0010);
    cycle(4'b0000, AF, BI, 1'b1);
    cycle(4'b0000, AF, BI, 1'b1);

    // Backpressure: requester 2 result held for 5 stalled cycles.
    cycle(4'b1111, AF, BI, 1'b0);
    check("bp_first_gnt", 32'(last_gnt), 32'b0100);
    cycle(4'b1111, AF, BI, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(4'b1111, AF, BI, 1'b0);
      check("bp_valid", 32'(last_vld), 32'd1);
      check("bp_gnt", 32'(last_gnt), 32'd0);
      check("bp_busy", 32'(last_busy), 32'd1);
      check("bp_out", 32'(last_out), 32'b0010);
      check("bp_id", 32'(last_id), 32'd2);
    end
    cycle(4'b1111, AF, BI, 1'b1);
    cycle(4'b1111, AF, BI, 1'b1);
    check("bp_next_gnt", 32'(last_gnt), 32'b1000);
    check("bp_next_busy", 32'(last_busy), 32'd0);

    // Reset during COMPUTE, then during RESULT with a nonzero counter.
    async_reset("rst_compute");
    cycle(4'b1000, AF, BI, 1'b1);
    check("rst_first_gnt", 32'(last_gnt), 32'b1000);
    cycle(4'b0000, AF, BI, 1'b1);
    cycle(4'b0000, AF, BI, 1'b1);
    cycle(4'b1111, AF, BI, 1'b0);
    check("rst_ptr0_gnt", 32'(last_gnt), 32'b0001);
    cycle(4'b0000, AF, BI, 1'b0);
    async_reset("rst_result");

    // Counter wrap on a single requester.
    do_reset();
    for (int k = 0; k < 256; k++) begin
      cycle(4'b0001, AF, 16'h0005, 1'b1);
      cycle(4'b0000, AF, 16'h0005, 1'b1);
      cycle(4'b0000, AF, 16'h0005, 1'b1);
    end
    cycle(4'b0000, AF, BI, 1'b1);
    check("cnt_wrap_256", 32'(last_cnt), 32'd0);
    cycle(4'b0001, AF, BI, 1'b1);
    cycle(4'b0000, AF, BI, 1'b1);
    cycle(4'b0000, AF, BI, 1'b1);
    cycle(4'b0000, AF, BI, 1'b1);
    check("cnt_257", 32'(last_cnt), 32'd1);

    // Randomized traffic with random stalls against the model.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      logic [R-1:0]   rr;
      logic [R*N-1:0] ra, rb;
      logic           rd;
      rr = R'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = 16'($urandom);
      rd = ($urandom_range(0, 3) != 0);
      cycle(rr, ra, rb, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
